// File: rtl/mem_ctl_mem_resp.sv
// Memory-side responder: captures a level request, performs the access into a
// register array after LATENCY cycles and answers with a four-phase mem_done.
module mem_ctl_mem_resp #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT = 4'(LATENCY);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              req_held;

    // Only the captured op's line matters once an access is in flight.
    assign req_held = op_wr ? mem_write : mem_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            mem_rdata <= '0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    mem_err <= mem_write & mem_read;
                    if (mem_write ^ mem_read) begin
                        op_wr   <= mem_write;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        cnt     <= LAT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    mem_err <= 1'b0;
                    // A dropped request aborts even on what would be the completion edge.
                    if (!req_held) begin
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        if (op_wr) begin
                            mem[addr_q] <= wdata_q;
                        end else begin
                            mem_rdata <= mem[addr_q];
                        end
                        cnt      <= '0;
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    mem_err <= 1'b0;
                    if (!req_held) begin
                        mem_done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    mem_err  <= 1'b0;
                    mem_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
